axi_write_master: RTL and testbench
===================================

# axi_write_master

AXI4 write master for the bottom-up RTL kernel data path. Accepts a start pulse with a base address and byte count, consumes an AXI4-Stream of data beats, and writes them to memory as aligned AXI4 INCR write bursts with a bounded number of outstanding transactions. It sits at the output end of the kernel, after the processing core, and mirrors the read master at the input end.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of the AXI4 interface
- C_M_AXI_DATA_WIDTH, 128, data width; one of 32, 64, 128, 256, 512, 1024
- C_XFER_SIZE_WIDTH, C_M_AXI_ADDR_WIDTH, width of ctrl_xfer_size_in_bytes; range 16..C_M_AXI_ADDR_WIDTH
- C_MAX_OUTSTANDING, 16, maximum number of AW requests issued without a B response
- C_MAX_BURST_LENGTH, 256, maximum beats per burst; effective burst BL = min(4096/(DW/8), C_MAX_BURST_LENGTH)

Ports:
- aclk  in  1  clock; all logic is on the rising edge
- areset_n  in  1  reset, asynchronous assert, active-low
- ctrl_start  in  1  one-cycle pulse that starts a transfer; ignored while busy
- ctrl_done  out  1  one-cycle pulse when the last B response is accepted
- ctrl_addr_offset  in  ADDR  start address, sampled with ctrl_start
- ctrl_xfer_size_in_bytes  in  XFER  byte count, sampled with ctrl_start
- m_axi_awvalid / m_axi_awready  out / in  1  AW handshake
- m_axi_awaddr  out  ADDR  burst address
- m_axi_awlen  out  8  beats minus one
- m_axi_wvalid / m_axi_wready  out / in  1  W handshake
- m_axi_wdata  out  DW  write data
- m_axi_wstrb  out  DW/8  byte strobes, always all ones
- m_axi_wlast  out  1  last beat of the current burst
- m_axi_bvalid / m_axi_bready  in / out  1  B handshake; bready is tied to 1 outside reset
- s_axis_tvalid / s_axis_tready  in / out  1  input stream handshake
- s_axis_tdata  in  DW  input stream data

## Operation
- States: IDLE, SETUP, ACTIVE, DRAIN. The only transition out of IDLE is ctrl_start.
- IDLE → SETUP: on ctrl_start. Latches the address masked down to a BL*DW/8 boundary. Latches beats = ceil(size / (DW/8)).
- SETUP (one cycle): computes the full-burst count and the final burst length. beats == 0 → go straight to DRAIN with zero transactions, so ctrl_done pulses with no AXI traffic. Otherwise → ACTIVE.
- AW issue:
  - Issue full bursts with awlen = BL-1. The final burst carries awlen = ((beats-1) mod BL).
  - The address increments by BL*DW/8 after each AW handshake.
  - awvalid is held, with awaddr/awlen stable, until awready.
- Outstanding limit: a vacancy counter initialises to C_MAX_OUTSTANDING. It decrements on AW handshake and increments on B handshake; both in the same cycle leave it unchanged. A new AW is not raised while the counter is 0.
- W channel:
  - Data passes straight through: m_axi_wvalid = s_axis_tvalid & w_enable, s_axis_tready = m_axi_wready & w_enable, wdata = tdata.
  - w_enable holds only while the number of AW handshakes completed exceeds the number of W bursts completed, so W never precedes its AW.
  - A beat counter drives wlast on beat awlen of the current burst.
- ACTIVE → DRAIN: after the final AW handshake and the final W beat (the wlast handshake of the last burst).
- DRAIN → IDLE: on the B handshake that brings the B count to the total transaction count; ctrl_done pulses on the next cycle.
- bresp is not examined.

## Timing
- Reset (areset_n low, asynchronous):
  - State returns to IDLE.
  - awvalid, wvalid, wlast, s_axis_tready and ctrl_done go to 0; bready goes to 0 while reset is held.
  - awaddr and awlen go to 0; all counters clear.
  - Deassertion takes effect on the next aclk edge.
- Latency: with ctrl_start at cycle N, awvalid asserts no earlier than N+2.
- ctrl_done asserts one cycle after the final B handshake, for exactly one cycle.
- W data never goes through a combinational path from awready.
- ctrl_start during SETUP, ACTIVE or DRAIN is ignored; there is no queueing.
- The beat count wraps only at the XFER width; sizes are not range-checked.

## Test plan
- DW=128, addr 0x1000_0010, size 64 → one AW: awaddr 0x1000_0000, awlen 3. Four W beats, wlast on the 4th. bvalid 3 cycles later → ctrl_done one cycle after the B handshake.
- Size 8224, addr 0 → three AWs: 0x0 len 255, 0x1000 len 255, 0x2000 len 1. 514 W beats with wlast at beats 256, 512 and 514. A single done pulse.
- Size 17 → awlen 1, two beats. Size 0 → ctrl_done pulses with no awvalid or wvalid.
- C_MAX_OUTSTANDING=2, size 20480, bvalid held low → exactly 2 AWs, then awvalid stays low. Releasing bvalid lets the remaining 3 AWs proceed. All 5 B responses are accepted before done.
- Random s_axis_tvalid / m_axi_wready / awready stalls with an incrementing data pattern → wdata sequence matches the input, awaddr/awlen are stable under stall, and no W beat precedes its AW.
- areset_n low mid-burst → all outputs go to reset values immediately. A new ctrl_start after release completes a 64-byte transfer correctly.

Source files
------------

// File: rtl/axi_write_master.sv
// AXI4 write master: turns an AXI4-Stream into aligned INCR write bursts
// with a bounded number of outstanding AW requests.
module axi_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_XFER_SIZE_WIDTH  = C_M_AXI_ADDR_WIDTH,
    parameter int C_MAX_OUTSTANDING  = 16,
    parameter int C_MAX_BURST_LENGTH = 256
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic                            ctrl_start,
    output logic                            ctrl_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata
);

    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int XW      = C_XFER_SIZE_WIDTH;
    localparam int BPB     = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int BL_4K   = 4096 / BPB;
    localparam int BL      = (BL_4K < C_MAX_BURST_LENGTH) ? BL_4K : C_MAX_BURST_LENGTH;
    localparam int LOG_BL  = $clog2(BL);
    localparam int VW      = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [AW-1:0] BURST_BYTES = AW'(BL * BPB);
    localparam logic [XW-1:0] BPB_M1      = XW'(BPB - 1);
    localparam logic [XW-1:0] BL_M1_X     = XW'(BL - 1);
    localparam logic [XW-1:0] ONE_X       = XW'(1);
    localparam logic [7:0]    FULL_LEN    = 8'(BL - 1);
    localparam logic [VW-1:0] VAC_MAX     = VW'(C_MAX_OUTSTANDING);
    localparam logic [VW-1:0] ONE_V       = VW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [XW-1:0]   beats_q;
    logic [XW-1:0]   total_q;
    logic [7:0]      final_len_q;
    logic [XW-1:0]   aw_cnt_q;
    logic [XW-1:0]   wb_cnt_q;
    logic [XW-1:0]   b_cnt_q;
    logic [7:0]      beat_q;
    logic [VW-1:0]   vac_q;
    logic [VW-1:0]   vac_d;
    logic            awvalid_q;
    logic [7:0]      awlen_q;
    logic            bready_q;
    logic            done_q;

    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            w_en;
    logic            last_burst;
    logic [7:0]      cur_len;
    logic            w_last;
    logic            b_final;

    // W is gated by registered counters only, so awready never reaches wdata/wvalid
    assign w_en       = (state_q == S_ACTIVE) && (aw_cnt_q > wb_cnt_q);
    assign aw_hs      = awvalid_q & m_axi_awready;
    assign w_hs       = m_axi_wvalid & m_axi_wready;
    assign b_hs       = m_axi_bvalid & bready_q;
    assign last_burst = (wb_cnt_q == (total_q - ONE_X));
    assign cur_len    = last_burst ? final_len_q : FULL_LEN;
    assign w_last     = w_en && (beat_q == cur_len);
    assign b_final    = (b_cnt_q == total_q)
                      || (b_hs && ((b_cnt_q + ONE_X) == total_q));

    always_comb begin
        vac_d = vac_q;
        if (aw_hs && !b_hs) begin
            vac_d = vac_q - ONE_V;
        end else if (b_hs && !aw_hs) begin
            vac_d = vac_q + ONE_V;
        end
    end

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_wvalid  = s_axis_tvalid & w_en;
    assign s_axis_tready = m_axi_wready & w_en;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_last;
    assign m_axi_bready  = bready_q;
    assign ctrl_done     = done_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            total_q     <= '0;
            final_len_q <= '0;
            aw_cnt_q    <= '0;
            wb_cnt_q    <= '0;
            b_cnt_q     <= '0;
            beat_q      <= '0;
            vac_q       <= VAC_MAX;
            awvalid_q   <= 1'b0;
            awlen_q     <= '0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bready_q <= 1'b1;
            done_q   <= 1'b0;
            vac_q    <= vac_d;
            if (b_hs) begin
                b_cnt_q <= b_cnt_q + ONE_X;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (ctrl_start) begin
                        addr_q   <= ctrl_addr_offset & ~(BURST_BYTES - AW'(1));
                        beats_q  <= (ctrl_xfer_size_in_bytes + BPB_M1) >> LOG_BPB;
                        aw_cnt_q <= '0;
                        wb_cnt_q <= '0;
                        b_cnt_q  <= '0;
                        beat_q   <= '0;
                        vac_q    <= VAC_MAX;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    final_len_q <= 8'((beats_q - ONE_X) & BL_M1_X);
                    if (beats_q == '0) begin
                        total_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        total_q <= ((beats_q - ONE_X) >> LOG_BL) + ONE_X;
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // one idle cycle between AWs keeps the vacancy check on settled state
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        addr_q    <= addr_q + BURST_BYTES;
                        aw_cnt_q  <= aw_cnt_q + ONE_X;
                    end else if (!awvalid_q && (aw_cnt_q != total_q)
                                 && (vac_q != '0)) begin
                        awvalid_q <= 1'b1;
                        awlen_q   <= (aw_cnt_q == (total_q - ONE_X))
                                   ? final_len_q : FULL_LEN;
                    end
                    if (w_hs) begin
                        if (w_last) begin
                            beat_q   <= '0;
                            wb_cnt_q <= wb_cnt_q + ONE_X;
                            if (last_burst) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (b_final) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: stimulus pushes expected AW/W/done
// records, a monitor pops and compares them on every DUT handshake.
module tb_axi_write_master;

    logic          aclk;
    logic          areset_n;
    logic          ctrl_start;
    logic          ctrl_done;
    logic [63:0]   ctrl_addr_offset;
    logic [63:0]   ctrl_xfer_size_in_bytes;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [63:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [127:0]  m_axi_wdata;
    logic [15:0]   m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [127:0]  s_axis_tdata;

    axi_write_master #(
        .C_M_AXI_ADDR_WIDTH(64),
        .C_M_AXI_DATA_WIDTH(128),
        .C_XFER_SIZE_WIDTH(64),
        .C_MAX_OUTSTANDING(2),
        .C_MAX_BURST_LENGTH(256)
    ) dut (
        .aclk                    (aclk),
        .areset_n                (areset_n),
        .ctrl_start              (ctrl_start),
        .ctrl_done               (ctrl_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .m_axi_awvalid           (m_axi_awvalid),
        .m_axi_awready           (m_axi_awready),
        .m_axi_awaddr            (m_axi_awaddr),
        .m_axi_awlen             (m_axi_awlen),
        .m_axi_wvalid            (m_axi_wvalid),
        .m_axi_wready            (m_axi_wready),
        .m_axi_wdata             (m_axi_wdata),
        .m_axi_wstrb             (m_axi_wstrb),
        .m_axi_wlast             (m_axi_wlast),
        .m_axi_bvalid            (m_axi_bvalid),
        .m_axi_bready            (m_axi_bready),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
    } w_exp_t;

    typedef struct packed {
        logic [31:0] bcnt;
        logic        after_b;
    } done_exp_t;

    aw_exp_t   exp_aw[$];
    w_exp_t    exp_w[$];
    done_exp_t exp_done[$];

    int vectors = 0;
    int miscompares = 0;

    int src_left = 0;
    int src_idx = 0;
    int push_idx = 0;
    int pend_b = 0;
    int aw_acc = 0;
    int w_bursts = 0;
    int w_tot = 0;
    int b_tot = 0;
    int exp_b_cum = 0;
    int done_cnt = 0;
    int aw_vcyc = 0;
    bit stall_en = 0;
    bit b_hold = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [127:0] pat(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {~v, v ^ 32'h5A5A_5A5A, v + 32'h0000_1000, v};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Slave/stream BFM plus monitor: sample at negedge, drive 1ns after posedge
    initial begin : bfm
        bit      stall_chk;
        bit      b_prev;
        logic [63:0] held_addr;
        logic [7:0]  held_len;
        aw_exp_t   ea;
        w_exp_t    ew;
        done_exp_t ed;
        stall_chk = 0;
        b_prev = 0;
        held_addr = '0;
        held_len = '0;
        m_axi_awready = 0;
        m_axi_wready = 0;
        m_axi_bvalid = 0;
        s_axis_tvalid = 0;
        s_axis_tdata = '0;
        forever begin
            @(negedge aclk);
            if (areset_n) begin
                if (stall_chk) begin
                    chk("aw_stall_valid", 128'(m_axi_awvalid), 128'd1);
                    chk("aw_stall_addr", 128'(m_axi_awaddr), 128'(held_addr));
                    chk("aw_stall_len", 128'(m_axi_awlen), 128'(held_len));
                end
                stall_chk = m_axi_awvalid && !m_axi_awready;
                held_addr = m_axi_awaddr;
                held_len = m_axi_awlen;
                if (m_axi_awvalid) aw_vcyc++;
                if (m_axi_wvalid && m_axi_wready) begin
                    chk("w_after_aw", 128'(aw_acc > w_bursts), 128'd1);
                    chk("wstrb", 128'(m_axi_wstrb), 128'hFFFF);
                    if (exp_w.size() == 0) begin
                        chk("w_unexpected", 128'(w_tot), 128'hFFFF_FFFF);
                    end else begin
                        ew = exp_w.pop_front();
                        chk("wdata", m_axi_wdata, ew.data);
                        chk("wlast", 128'(m_axi_wlast), 128'(ew.last));
                    end
                    if (m_axi_wlast) begin
                        w_bursts++;
                        pend_b++;
                    end
                    w_tot++;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexpected", 128'(m_axi_awaddr), 128'hFFFF_FFFF);
                    end else begin
                        ea = exp_aw.pop_front();
                        chk("awaddr", 128'(m_axi_awaddr), 128'(ea.addr));
                        chk("awlen", 128'(m_axi_awlen), 128'(ea.len));
                    end
                    aw_acc++;
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    src_left--;
                    src_idx++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    pend_b--;
                    b_tot++;
                end
                if (ctrl_done) begin
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 128'(ctrl_done), 128'd0);
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_bcount", 128'(b_tot), 128'(ed.bcnt));
                        if (ed.after_b) chk("done_latency", 128'(b_prev), 128'd1);
                    end
                    done_cnt++;
                end
                b_prev = m_axi_bvalid && m_axi_bready;
            end else begin
                stall_chk = 0;
                b_prev = 0;
            end
            @(posedge aclk);
            #1;
            if (!areset_n) begin
                m_axi_awready = 0;
                m_axi_wready = 0;
                m_axi_bvalid = 0;
                s_axis_tvalid = 0;
            end else begin
                m_axi_awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
                m_axi_wready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_axis_tvalid = (src_left > 0)
                              && (!stall_en || $urandom_range(0, 3) != 0);
                s_axis_tdata = pat(src_idx);
                m_axi_bvalid = (pend_b > 0) && !b_hold
                             && (!stall_en || $urandom_range(0, 1) == 0);
            end
        end
    end

    task automatic push_aw(input logic [63:0] a, input logic [7:0] l);
        aw_exp_t e;
        e.addr = a;
        e.len = l;
        exp_aw.push_back(e);
    endtask

    task automatic xfer(input logic [63:0] addr, input logic [63:0] size,
                        input int beats, input int nb);
        w_exp_t e;
        done_exp_t d;
        for (int i = 0; i < beats; i++) begin
            e.data = pat(push_idx);
            e.last = ((i % 256) == 255) || (i == beats - 1);
            exp_w.push_back(e);
            push_idx++;
        end
        exp_b_cum += nb;
        d.bcnt = 32'(exp_b_cum);
        d.after_b = (nb > 0);
        exp_done.push_back(d);
        @(posedge aclk);
        #1;
        ctrl_start = 1;
        ctrl_addr_offset = addr;
        ctrl_xfer_size_in_bytes = size;
        @(posedge aclk);
        #1;
        ctrl_start = 0;
        chk("aw_latency", 128'(m_axi_awvalid), 128'd0);
        src_left += beats;
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge aclk);
            n++;
        end
        if (done_cnt == c0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles", budget);
        end
        repeat (4) @(posedge aclk);
        chk("done_once", 128'(done_cnt), 128'(c0 + 1));
        chk("aw_queue_empty", 128'(exp_aw.size()), 128'd0);
        chk("w_queue_empty", 128'(exp_w.size()), 128'd0);
    endtask

    initial begin : stim
        int base_aw;
        int base_w;
        int n;
        areset_n = 0;
        ctrl_start = 0;
        ctrl_addr_offset = '0;
        ctrl_xfer_size_in_bytes = '0;
        #12;
        chk("rst_awvalid", 128'(m_axi_awvalid), 128'd0);
        chk("rst_wvalid", 128'(m_axi_wvalid), 128'd0);
        chk("rst_wlast", 128'(m_axi_wlast), 128'd0);
        chk("rst_tready", 128'(s_axis_tready), 128'd0);
        chk("rst_done", 128'(ctrl_done), 128'd0);
        chk("rst_bready", 128'(m_axi_bready), 128'd0);
        chk("rst_awaddr", 128'(m_axi_awaddr), 128'd0);
        chk("rst_awlen", 128'(m_axi_awlen), 128'd0);
        @(posedge aclk);
        #3;
        areset_n = 1;
        repeat (2) @(posedge aclk);
        #1;
        chk("bready_up", 128'(m_axi_bready), 128'd1);

        push_aw(64'h1000_0000, 8'd3);
        xfer(64'h1000_0010, 64'd64, 4, 1);
        wait_done(200);

        push_aw(64'h0000_0000, 8'd255);
        push_aw(64'h0000_1000, 8'd255);
        push_aw(64'h0000_2000, 8'd1);
        xfer(64'h0, 64'd8224, 514, 3);
        repeat (50) @(posedge aclk);
        #1;
        ctrl_start = 1;
        ctrl_addr_offset = 64'h5000;
        ctrl_xfer_size_in_bytes = 64'd16;
        @(posedge aclk);
        #1;
        ctrl_start = 0;
        wait_done(3000);

        push_aw(64'h0, 8'd1);
        xfer(64'h40, 64'd17, 2, 1);
        wait_done(200);

        base_aw = aw_vcyc;
        base_w = w_tot;
        xfer(64'h100, 64'd0, 0, 0);
        wait_done(50);
        chk("zero_no_aw", 128'(aw_vcyc), 128'(base_aw));
        chk("zero_no_w", 128'(w_tot), 128'(base_w));

        b_hold = 1;
        base_aw = aw_acc;
        base_w = w_tot;
        for (int i = 0; i < 5; i++) push_aw(64'(i) * 64'h1000, 8'd255);
        xfer(64'h0, 64'd20480, 1280, 5);
        n = 0;
        while (w_tot < base_w + 512 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        repeat (20) @(posedge aclk);
        #1;
        chk("outstanding_aws", 128'(aw_acc - base_aw), 128'd2);
        chk("outstanding_hold", 128'(m_axi_awvalid), 128'd0);
        b_hold = 0;
        wait_done(4000);

        stall_en = 1;
        push_aw(64'h3000, 8'd255);
        push_aw(64'h4000, 8'd6);
        xfer(64'h3000, 64'd4200, 263, 2);
        wait_done(5000);
        stall_en = 0;

        push_aw(64'h0000_0000, 8'd255);
        push_aw(64'h0000_1000, 8'd255);
        push_aw(64'h0000_2000, 8'd1);
        xfer(64'h0, 64'd8224, 514, 3);
        repeat (100) @(posedge aclk);
        #3;
        areset_n = 0;
        #1;
        chk("mid_rst_awvalid", 128'(m_axi_awvalid), 128'd0);
        chk("mid_rst_wvalid", 128'(m_axi_wvalid), 128'd0);
        chk("mid_rst_wlast", 128'(m_axi_wlast), 128'd0);
        chk("mid_rst_tready", 128'(s_axis_tready), 128'd0);
        chk("mid_rst_bready", 128'(m_axi_bready), 128'd0);
        chk("mid_rst_awaddr", 128'(m_axi_awaddr), 128'd0);
        chk("mid_rst_awlen", 128'(m_axi_awlen), 128'd0);
        exp_aw.delete();
        exp_w.delete();
        exp_done.delete();
        src_left = 0;
        src_idx = 0;
        push_idx = 0;
        pend_b = 0;
        aw_acc = 0;
        w_bursts = 0;
        b_tot = 0;
        exp_b_cum = 0;
        repeat (3) @(posedge aclk);
        #3;
        areset_n = 1;
        repeat (2) @(posedge aclk);

        push_aw(64'h0, 8'd3);
        xfer(64'h80, 64'd64, 4, 1);
        wait_done(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
